sbox_result_uart: RTL

- Downstream consumer of the 32-bit S-box result register in the power-analysis demo.
- Accepts each result word on a one-cycle strobe and buffers it in a small FIFO.
- Streams each word to the host over an 8N1 UART frame, prefixed by a sync byte, so captured traces can be paired with the S-box outputs.
- Sits between the S-box output register and the board UART TX pin.

---
 rtl/sbox_result_uart_if.sv | 22 ++
 rtl/sbox_result_uart.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sbox_result_uart_if.sv
// Result-word bus between the S-box result register and the UART streamer.
interface sbox_result_uart_if;
  logic [31:0] word_in;
  logic        word_valid;
  logic        clr_overflow;
  logic        uart_tx;
  logic        busy;
  logic        fifo_full;
  logic        overflow;

  // Producer side: pushes words, observes TX line and status.
  modport master (
    output word_in, word_valid, clr_overflow,
    input  uart_tx, busy, fifo_full, overflow
  );

  // Streamer side.
  modport slave (
    input  word_in, word_valid, clr_overflow,
    output uart_tx, busy, fifo_full, overflow
  );
endinterface

// File: rtl/sbox_result_uart.sv
// Buffers 32-bit S-box result words in a small FIFO and streams each one over
// an 8N1 UART as a five-byte frame: SYNC_BYTE followed by the word MSB first.
module sbox_result_uart #(
  parameter int          CLK_DIV   = 104,
  parameter int          FIFO_AW   = 2,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                ICE_CLK,
  input  logic                resetn,
  sbox_result_uart_if.slave   bus
);

  localparam int          DEPTH  = 1 << FIFO_AW;
  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [31:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               full_q, empty_q, ovf_q;
  logic               push, pop;

  // Transmitter state
  state_t      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [2:0]  byte_q;
  logic [31:0] hold_q;
  logic [7:0]  sh_q;
  logic        tx_q;
  logic        busy_q;

  // The head is consumed only while in LOAD; a push into a full FIFO is still
  // accepted when that pop frees a slot on the same edge.
  assign pop  = (state_q == LOAD);
  assign push = bus.word_valid && (!full_q || pop);

  // Next occupancy; push and pop together leave it unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // FIFO data array; no reset needed since the pointers gate every read.
  always_ff @(posedge ICE_CLK) begin
    if (push) mem_q[wr_ptr_q] <= bus.word_in;
  end

  // Pointers, occupancy, registered full/empty flags and sticky overflow.
  always_ff @(posedge ICE_CLK or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == (FIFO_AW+1)'(DEPTH));
      empty_q <= (count_d == '0);
      // A dropped push wins over a simultaneous clear.
      if (bus.word_valid && !push) ovf_q <= 1'b1;
      else if (bus.clr_overflow)   ovf_q <= 1'b0;
    end
  end

  // Frame sequencer; the TX line and busy flag come straight from registers.
  always_ff @(posedge ICE_CLK or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      hold_q  <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (!empty_q) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          hold_q  <= mem_q[rd_ptr_q];
          byte_q  <= '0;
          sh_q    <= SYNC_BYTE;
          cnt_q   <= DIV_M1;
          tx_q    <= 1'b0;
          state_q <= START;
        end
        START: begin
          if (cnt_q == '0) begin
            tx_q    <= sh_q[0];
            sh_q    <= {1'b0, sh_q[7:1]};
            bit_q   <= '0;
            cnt_q   <= DIV_M1;
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == '0) begin
            cnt_q <= DIV_M1;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              tx_q  <= sh_q[0];
              sh_q  <= {1'b0, sh_q[7:1]};
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == '0) begin
            if (byte_q < 3'd4) begin
              // Next payload byte, MSB byte of the word first.
              case (byte_q)
                3'd0:    sh_q <= hold_q[31:24];
                3'd1:    sh_q <= hold_q[23:16];
                3'd2:    sh_q <= hold_q[15:8];
                default: sh_q <= hold_q[7:0];
              endcase
              byte_q  <= byte_q + 1'b1;
              cnt_q   <= DIV_M1;
              tx_q    <= 1'b0;
              state_q <= START;
            end else if (!empty_q) begin
              state_q <= LOAD;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.uart_tx   = tx_q;
  assign bus.busy      = busy_q;
  assign bus.fifo_full = full_q;
  assign bus.overflow  = ovf_q;

endmodule
